// File: rtl/calc_entry_ctrl.sv
// Keypad-entry controller: assembles two BCD operands, latches the operator and
// runs a req/ack transaction with the BCD arithmetic unit. Define CALC_CHAIN_EN to chain operators.
module calc_entry_ctrl #(
  parameter int DIGITS = 6
) (
  input  logic                CLK_1K,
  input  logic                RSTN,
  input  logic                key_valid,
  input  logic [3:0]          key_value,
  input  logic [4*DIGITS-1:0] result,
  input  logic                result_valid,
  input  logic                result_err,
  output logic [4*DIGITS-1:0] operand_a,
  output logic [4*DIGITS-1:0] operand_b,
  output logic [1:0]          opcode,
  output logic                calc_req,
  output logic [4*DIGITS-1:0] disp_out,
  output logic                entry_full,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, CALC, SHOW, ERROR} state_t;

  state_t        state, n_state;
  logic [W-1:0]  n_a, n_b, n_disp;
  logic [CW-1:0] cnt_a, cnt_b, n_cnt_a, n_cnt_b;
  logic [1:0]    n_opcode, key_op;
  logic          n_req, n_err, n_full;
  logic          is_digit, is_oper, is_equ, is_clr;
`ifdef CALC_CHAIN_EN
  logic [1:0]    pend_op, n_pend;
  logic          chain, n_chain;
`endif

  assign is_digit = key_valid && (key_value <= 4'd9);
  assign is_oper  = key_valid && (key_value >= 4'hA) && (key_value <= 4'hD);
  assign is_equ   = key_valid && (key_value == 4'hE);
  assign is_clr   = key_valid && (key_value == 4'hF);
  // A..D have low bits 10,11,00,01; subtracting 2 mod 4 yields 00..11
  assign key_op   = key_value[1:0] - 2'b10;

  function automatic logic [CW-1:0] sig_digits(input logic [W-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'd0) n = CW'(i + 1);
    return n;
  endfunction

  always_comb begin
    n_state  = state;
    n_a      = operand_a;
    n_b      = operand_b;
    n_cnt_a  = cnt_a;
    n_cnt_b  = cnt_b;
    n_opcode = opcode;
    n_req    = calc_req;
    n_err    = err;
`ifdef CALC_CHAIN_EN
    n_pend   = pend_op;
    n_chain  = chain;
`endif
    if (is_clr) begin
      n_state  = ENTER_A;
      n_a      = '0;
      n_b      = '0;
      n_cnt_a  = '0;
      n_cnt_b  = '0;
      n_opcode = '0;
      n_req    = 1'b0;
      n_err    = 1'b0;
`ifdef CALC_CHAIN_EN
      n_pend   = '0;
      n_chain  = 1'b0;
`endif
    end else begin
      case (state)
        ENTER_A: begin
          if (is_digit) begin
            if (cnt_a != CW'(DIGITS)) begin
              n_a = (operand_a << 4) | W'(key_value);
              if (!(operand_a == '0 && key_value == 4'd0)) n_cnt_a = cnt_a + CW'(1);
            end
          end else if (is_oper) begin
            n_opcode = key_op;
            n_state  = OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (is_oper) n_opcode = key_op;
          else if (is_digit) begin
            n_b     = W'(key_value);
            n_cnt_b = (key_value != 4'd0) ? CW'(1) : '0;
            n_state = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_digit) begin
            if (cnt_b != CW'(DIGITS)) begin
              n_b = (operand_b << 4) | W'(key_value);
              if (!(operand_b == '0 && key_value == 4'd0)) n_cnt_b = cnt_b + CW'(1);
            end
          end else if (is_equ) begin
            n_req   = 1'b1;
            n_state = CALC;
          end else if (is_oper) begin
`ifdef CALC_CHAIN_EN
            // current opcode goes out with this request; the new one waits
            n_req   = 1'b1;
            n_pend  = key_op;
            n_chain = 1'b1;
            n_state = CALC;
`else
            n_opcode = key_op;
`endif
          end
        end
        CALC: begin
          if (calc_req && result_valid) begin
            n_req = 1'b0;
            if (result_err) begin
              n_err   = 1'b1;
              n_state = ERROR;
            end else begin
              n_a     = result;
              n_b     = '0;
              n_cnt_b = '0;
              n_cnt_a = sig_digits(result);
              n_state = SHOW;
`ifdef CALC_CHAIN_EN
              if (chain) begin
                n_opcode = pend_op;
                n_state  = OP_WAIT;
              end
`endif
            end
`ifdef CALC_CHAIN_EN
            n_chain = 1'b0;
`endif
          end
        end
        SHOW: begin
          if (is_digit) begin
            n_a     = W'(key_value);
            n_cnt_a = (key_value != 4'd0) ? CW'(1) : '0;
            n_state = ENTER_A;
          end else if (is_oper) begin
            n_opcode = key_op;
            n_state  = OP_WAIT;
          end
        end
        default: ;
      endcase
    end

    case (n_state)
      ENTER_B, CALC: n_disp = n_b;
      ERROR:         n_disp = '0;
      default:       n_disp = n_a;
    endcase
    case (n_state)
      ENTER_A: n_full = (n_cnt_a == CW'(DIGITS));
      ENTER_B: n_full = (n_cnt_b == CW'(DIGITS));
      default: n_full = 1'b0;
    endcase
  end

  always_ff @(posedge CLK_1K or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ENTER_A;
      operand_a  <= '0;
      operand_b  <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      opcode     <= '0;
      calc_req   <= 1'b0;
      err        <= 1'b0;
      disp_out   <= '0;
      entry_full <= 1'b0;
`ifdef CALC_CHAIN_EN
      pend_op    <= '0;
      chain      <= 1'b0;
`endif
    end else begin
      state      <= n_state;
      operand_a  <= n_a;
      operand_b  <= n_b;
      cnt_a      <= n_cnt_a;
      cnt_b      <= n_cnt_b;
      opcode     <= n_opcode;
      calc_req   <= n_req;
      err        <= n_err;
      disp_out   <= n_disp;
      entry_full <= n_full;
`ifdef CALC_CHAIN_EN
      pend_op    <= n_pend;
      chain      <= n_chain;
`endif
    end
  end
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: vector table, decimal-value reference model under random keys,
// hand sequences for chaining and async reset. Honours CALC_CHAIN_EN like the design.
`timescale 1ns/1ps
module tb_calc_entry_ctrl;
  localparam int DIG = 6;

  logic        CLK_1K = 1'b0;
  logic        RSTN = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_value = '0;
  logic [23:0] result = '0;
  logic        result_valid = 1'b0;
  logic        result_err = 1'b0;
  logic [23:0] operand_a, operand_b, disp_out;
  logic [1:0]  opcode;
  logic        calc_req, entry_full, err;

  int checks = 0;
  int failures = 0;

  calc_entry_ctrl #(.DIGITS(DIG)) dut (
    .CLK_1K(CLK_1K), .RSTN(RSTN), .key_valid(key_valid), .key_value(key_value),
    .result(result), .result_valid(result_valid), .result_err(result_err),
    .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode), .calc_req(calc_req),
    .disp_out(disp_out), .entry_full(entry_full), .err(err)
  );

  always #5 CLK_1K = ~CLK_1K;

  typedef struct {
    bit kv; logic [3:0] k; bit rv; bit re; logic [23:0] r;
    logic [23:0] a; logic [23:0] b; logic [1:0] op; bit req; logic [23:0] d; bit full; bit er;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit kv, logic [3:0] k, bit rv, bit re, logic [23:0] r,
                              logic [23:0] a, logic [23:0] b, logic [1:0] op, bit req,
                              logic [23:0] d, bit full, bit er);
    vec_t v;
    v.kv = kv; v.k = k; v.rv = rv; v.re = re; v.r = r;
    v.a = a; v.b = b; v.op = op; v.req = req; v.d = d; v.full = full; v.er = er;
    tbl.push_back(v);
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, logic [23:0] a, logic [23:0] b, logic [1:0] op, bit req,
                           logic [23:0] d, bit full, bit er);
    check({tag, ".operand_a"}, 64'(operand_a), 64'(a));
    check({tag, ".operand_b"}, 64'(operand_b), 64'(b));
    check({tag, ".opcode"}, 64'(opcode), 64'(op));
    check({tag, ".calc_req"}, 64'(calc_req), 64'(req));
    check({tag, ".disp_out"}, 64'(disp_out), 64'(d));
    check({tag, ".entry_full"}, 64'(entry_full), 64'(full));
    check({tag, ".err"}, 64'(err), 64'(er));
  endtask

  task automatic step(bit kv, logic [3:0] k, bit rv, bit re, logic [23:0] r);
    @(negedge CLK_1K);
    key_valid = kv; key_value = k; result_valid = rv; result_err = re; result = r;
    @(posedge CLK_1K);
    #1;
  endtask

  // Reference model: operands held as plain decimal numbers, digit count = decimal length
  localparam int S_A = 0, S_OPW = 1, S_B = 2, S_CALC = 3, S_SHOW = 4, S_ERR = 5;
  int m_st, mop, mpend;
  longint ma, mb;
  bit mreq, merr, mchain;

  function automatic int ndig(longint v);
    int n = 0;
    while (v > 0) begin n++; v = v / 10; end
    return n;
  endfunction

  function automatic logic [23:0] to_bcd(longint v);
    logic [23:0] r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_st = S_A; ma = 0; mb = 0; mop = 0; mpend = 0; mreq = 0; merr = 0; mchain = 0;
  endtask

  task automatic model_step(bit kv, int k, bit rv, bit re, longint rdec);
    bit dg, ok, eq;
    dg = kv && k <= 9; ok = kv && k >= 10 && k <= 13; eq = kv && k == 14;
    if (kv && k == 15) begin model_clear(); return; end
    case (m_st)
      S_A: if (dg) begin if (ndig(ma) < DIG) ma = ma * 10 + k; end
           else if (ok) begin mop = k - 10; m_st = S_OPW; end
      S_OPW: if (ok) mop = k - 10;
             else if (dg) begin mb = k; m_st = S_B; end
      S_B: if (dg) begin if (ndig(mb) < DIG) mb = mb * 10 + k; end
           else if (eq) begin mreq = 1; m_st = S_CALC; end
           else if (ok) begin
`ifdef CALC_CHAIN_EN
             mreq = 1; mpend = k - 10; mchain = 1; m_st = S_CALC;
`else
             mop = k - 10;
`endif
           end
      S_CALC: if (mreq && rv) begin
                mreq = 0;
                if (re) begin merr = 1; m_st = S_ERR; end
                else begin
                  ma = rdec; mb = 0;
                  if (mchain) begin mop = mpend; m_st = S_OPW; end
                  else m_st = S_SHOW;
                end
                mchain = 0;
              end
      S_SHOW: if (dg) begin ma = k; m_st = S_A; end
              else if (ok) begin mop = k - 10; m_st = S_OPW; end
      default: ;
    endcase
  endtask

  task automatic model_compare();
    logic [23:0] d;
    bit full;
    d = (m_st == S_B || m_st == S_CALC) ? to_bcd(mb) : (m_st == S_ERR) ? 24'h0 : to_bcd(ma);
    full = (m_st == S_A) ? (ndig(ma) == DIG) : (m_st == S_B) ? (ndig(mb) == DIG) : 1'b0;
    check_all("rand", to_bcd(ma), to_bcd(mb), 2'(mop), mreq, d, full, merr);
  endtask

  initial begin
    // Table: one record per cycle, applied back to back from reset
    add(1,4'hF,0,0,0,      0,0,0,0,0,0,0);
    add(1,4'h1,0,0,0,      24'h1,0,0,0,24'h1,0,0);
    add(1,4'h2,0,0,0,      24'h12,0,0,0,24'h12,0,0);
    add(1,4'hA,0,0,0,      24'h12,0,0,0,24'h12,0,0);
    add(1,4'h3,0,0,0,      24'h12,24'h3,0,0,24'h3,0,0);
    add(1,4'hE,0,0,0,      24'h12,24'h3,0,1,24'h3,0,0);
    add(0,4'h0,0,0,0,      24'h12,24'h3,0,1,24'h3,0,0);
    add(0,4'h0,1,0,24'h15, 24'h15,0,0,0,24'h15,0,0);
    add(1,4'hE,0,0,0,      24'h15,0,0,0,24'h15,0,0);
    add(1,4'hF,0,0,0,      0,0,0,0,0,0,0);
    add(1,4'h1,0,0,0,      24'h1,0,0,0,24'h1,0,0);
    add(1,4'h2,0,0,0,      24'h12,0,0,0,24'h12,0,0);
    add(1,4'h3,0,0,0,      24'h123,0,0,0,24'h123,0,0);
    add(1,4'h4,0,0,0,      24'h1234,0,0,0,24'h1234,0,0);
    add(1,4'h5,0,0,0,      24'h12345,0,0,0,24'h12345,0,0);
    add(1,4'h6,0,0,0,      24'h123456,0,0,0,24'h123456,1,0);
    add(1,4'h7,0,0,0,      24'h123456,0,0,0,24'h123456,1,0);
    add(1,4'hF,0,0,0,      0,0,0,0,0,0,0);
    add(1,4'h0,0,0,0,      0,0,0,0,0,0,0);
    add(1,4'h0,0,0,0,      0,0,0,0,0,0,0);
    add(1,4'h5,0,0,0,      24'h5,0,0,0,24'h5,0,0);
    add(1,4'h1,0,0,0,      24'h51,0,0,0,24'h51,0,0);
    add(1,4'h2,0,0,0,      24'h512,0,0,0,24'h512,0,0);
    add(1,4'h3,0,0,0,      24'h5123,0,0,0,24'h5123,0,0);
    add(1,4'h4,0,0,0,      24'h51234,0,0,0,24'h51234,0,0);
    add(1,4'h5,0,0,0,      24'h512345,0,0,0,24'h512345,1,0);
    add(1,4'hF,0,0,0,      0,0,0,0,0,0,0);
    add(1,4'h8,0,0,0,      24'h8,0,0,0,24'h8,0,0);
    add(1,4'hD,0,0,0,      24'h8,0,3,0,24'h8,0,0);
    add(1,4'h0,0,0,0,      24'h8,0,3,0,0,0,0);
    add(1,4'hE,0,0,0,      24'h8,0,3,1,0,0,0);
    add(0,4'h0,1,1,24'h123,24'h8,0,3,0,0,0,1);
    add(1,4'h5,0,0,0,      24'h8,0,3,0,0,0,1);
    add(1,4'hE,0,0,0,      24'h8,0,3,0,0,0,1);
    add(1,4'hF,0,0,0,      0,0,0,0,0,0,0);
    add(1,4'h9,0,0,0,      24'h9,0,0,0,24'h9,0,0);
    add(1,4'hA,0,0,0,      24'h9,0,0,0,24'h9,0,0);
    add(1,4'hB,0,0,0,      24'h9,0,1,0,24'h9,0,0);
    add(1,4'hC,0,0,0,      24'h9,0,2,0,24'h9,0,0);
    add(1,4'h2,0,0,0,      24'h9,24'h2,2,0,24'h2,0,0);
    add(0,4'h0,1,0,24'h999999, 24'h9,24'h2,2,0,24'h2,0,0);
    add(1,4'hE,0,0,0,      24'h9,24'h2,2,1,24'h2,0,0);
    add(1,4'hF,0,0,0,      0,0,0,0,0,0,0);
    add(0,4'h0,1,0,24'h42, 0,0,0,0,0,0,0);
    add(1,4'h1,0,0,0,      24'h1,0,0,0,24'h1,0,0);
    add(1,4'hA,0,0,0,      24'h1,0,0,0,24'h1,0,0);
    add(1,4'h1,0,0,0,      24'h1,24'h1,0,0,24'h1,0,0);
    add(1,4'hE,0,0,0,      24'h1,24'h1,0,1,24'h1,0,0);
    add(1,4'hF,1,0,24'h2,  0,0,0,0,0,0,0);
    add(1,4'h1,0,0,0,      24'h1,0,0,0,24'h1,0,0);
    add(1,4'hA,0,0,0,      24'h1,0,0,0,24'h1,0,0);
    add(1,4'h1,0,0,0,      24'h1,24'h1,0,0,24'h1,0,0);
    add(1,4'hE,0,0,0,      24'h1,24'h1,0,1,24'h1,0,0);
    add(1,4'h5,1,0,24'h2,  24'h2,0,0,0,24'h2,0,0);
    add(1,4'h7,0,0,0,      24'h7,0,0,0,24'h7,0,0);
    add(1,4'h3,0,0,0,      24'h73,0,0,0,24'h73,0,0);

    // Reset values
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK_1K);
    RSTN = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].kv, tbl[i].k, tbl[i].rv, tbl[i].re, tbl[i].r);
      check_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].req,
                tbl[i].d, tbl[i].full, tbl[i].er);
    end

    // Randomized run against the decimal model
    step(1, 4'hF, 0, 0, 0);
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      bit kv, rv, re;
      int k, sel;
      longint rdec;
      kv = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 99);
      if (sel < 60) k = $urandom_range(0, 9);
      else if (sel < 78) k = $urandom_range(10, 13);
      else if (sel < 93) k = 14;
      else k = 15;
      rv = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 4) == 0);
      rdec = longint'($urandom_range(0, 999999));
      step(kv, 4'(k), rv, re, to_bcd(rdec));
      model_step(kv, k, rv, re, rdec);
      model_compare();
    end

    // Operator while editing B
    step(1, 4'hF, 0, 0, 0);
    step(1, 4'h4, 0, 0, 0);
    step(1, 4'hA, 0, 0, 0);
    step(1, 4'h5, 0, 0, 0);
    step(1, 4'hC, 0, 0, 0);
`ifdef CALC_CHAIN_EN
    check_all("chain_req", 24'h4, 24'h5, 2'b00, 1, 24'h5, 0, 0);
    step(0, 4'h0, 0, 0, 0);
    check_all("chain_hold", 24'h4, 24'h5, 2'b00, 1, 24'h5, 0, 0);
    step(0, 4'h0, 1, 0, 24'h9);
    check_all("chain_res", 24'h9, 0, 2'b10, 0, 24'h9, 0, 0);
    step(1, 4'h2, 0, 0, 0);
    step(1, 4'hE, 0, 0, 0);
    check_all("chain_eq", 24'h9, 24'h2, 2'b10, 1, 24'h2, 0, 0);
    step(0, 4'h0, 1, 0, 24'h18);
    check_all("chain_res2", 24'h18, 0, 2'b10, 0, 24'h18, 0, 0);
`else
    check_all("b_oper", 24'h4, 24'h5, 2'b10, 0, 24'h5, 0, 0);
    step(1, 4'h6, 0, 0, 0);
    check_all("b_oper_dig", 24'h4, 24'h56, 2'b10, 0, 24'h56, 0, 0);
    step(1, 4'hE, 0, 0, 0);
    step(0, 4'h0, 1, 0, 24'h100);
    check_all("b_oper_res", 24'h100, 0, 2'b10, 0, 24'h100, 0, 0);
`endif

    // Asynchronous reset in the middle of a request
    step(1, 4'hF, 0, 0, 0);
    step(1, 4'h1, 0, 0, 0);
    step(1, 4'hA, 0, 0, 0);
    step(1, 4'h1, 0, 0, 0);
    step(1, 4'hE, 0, 0, 0);
    check("areset.pre_req", 64'(calc_req), 64'd1);
    @(negedge CLK_1K);
    key_valid = 1'b0;
    #2 RSTN = 1'b0;
    #1;
    check_all("areset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK_1K);
    RSTN = 1'b1;
    step(0, 4'h0, 1, 0, 24'h77);
    check_all("areset_late", 0, 0, 0, 0, 0, 0, 0);
    step(1, 4'h3, 0, 0, 0);
    check_all("areset_entry", 24'h3, 0, 0, 0, 24'h3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
